// File: rtl/nn_fp_pkg.sv
// Shared definitions for the neuron datapath: FSM states, FP constants,
// exception-flag positions and rounding helpers used by the FP units.
package nn_fp_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_HALF = 32'h3f00_0000;
  localparam logic [31:0] FP_ONE  = 32'h3f80_0000;

  localparam int EXC_NX = 0;  // inexact
  localparam int EXC_UF = 1;  // underflow
  localparam int EXC_OF = 2;  // overflow
  localparam int EXC_DZ = 3;  // divide by zero
  localparam int EXC_NV = 4;  // invalid

  localparam logic [2:0] RND_RNE = 3'd0;
  localparam logic [2:0] RND_RTZ = 3'd1;
  localparam logic [2:0] RND_RDN = 3'd2;
  localparam logic [2:0] RND_RUP = 3'd3;
  localparam logic [2:0] RND_RMM = 3'd4;

  function automatic logic round_inc(input logic sign, input logic lsb, input logic guard,
                                     input logic sticky, input logic [2:0] mode);
    case (mode)
      RND_RTZ: return 1'b0;
      RND_RDN: return sign & (guard | sticky);
      RND_RUP: return ~sign & (guard | sticky);
      RND_RMM: return guard;
      default: return guard & (sticky | lsb);
    endcase
  endfunction

  // Whether an overflowing result becomes infinity (else the largest finite value).
  function automatic logic ovf_to_inf(input logic sign, input logic [2:0] mode);
    case (mode)
      RND_RTZ: return 1'b0;
      RND_RDN: return sign;
      RND_RUP: return ~sign;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/add_sub.sv
// Combinational FP adder/subtractor (op_i=1 subtracts b); subnormals flush to zero.
module add_sub
  import nn_fp_pkg::*;
#(
  parameter int exp_width  = 8,
  parameter int mant_width = 24
) (
  input  logic [exp_width+mant_width-1:0] a_i,
  input  logic [exp_width+mant_width-1:0] b_i,
  input  logic                            op_i,
  input  logic [2:0]                      round_mode_i,
  output logic [exp_width+mant_width-1:0] z_o,
  output logic [4:0]                      exc_o
);
  localparam int E    = exp_width;
  localparam int F    = mant_width - 1;
  localparam int M    = mant_width;
  localparam int EMAX = (1 << E) - 1;
  localparam int SW   = M + 4;  // carry, mantissa, guard, round, sticky

  logic          sa, sb, sbe, swap, s_big, s_sml, zs;
  logic [E-1:0]  ea, eb, e_big, e_sml;
  logic [F-1:0]  fa, fb;
  logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [M-1:0]  ma, mb, m_big, m_sml, mant;
  logic [M:0]    mant_r;
  logic [SW-1:0] big_x, sml_x, shifted, sum, norm;
  logic          guard, sticky, up;
  int            diff, lz, exp_i;

  assign {sa, ea, fa} = a_i;
  assign {sb, eb, fb} = b_i;

  always_comb begin
    sbe    = sb ^ op_i;
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    ma     = {~a_zero, fa};
    mb     = {~b_zero, fb};
    swap   = {eb, fb} > {ea, fa};
    s_big  = swap ? sbe : sa;
    s_sml  = swap ? sa : sbe;
    e_big  = swap ? eb : ea;
    e_sml  = swap ? ea : eb;
    m_big  = swap ? mb : ma;
    m_sml  = swap ? ma : mb;
    diff   = int'(e_big) - int'(e_sml);
    big_x  = {1'b0, m_big, 3'b000};
    sml_x  = {1'b0, m_sml, 3'b000};
    if (diff >= SW) begin
      shifted    = '0;
      shifted[0] = |m_sml;
    end else begin
      shifted    = sml_x >> diff;
      shifted[0] = shifted[0] | (|(sml_x & ~({SW{1'b1}} << diff)));
    end
    sum = (s_big == s_sml) ? big_x + shifted : big_x - shifted;
    lz  = SW;
    for (int i = 0; i < SW; i++) begin
      if (sum[i]) lz = SW - 1 - i;
    end
    norm   = sum << lz;
    exp_i  = int'(e_big) + 1 - lz;
    mant   = norm[SW-1 -: M];
    guard  = norm[SW-1-M];
    sticky = |norm[SW-2-M:0];
    up     = round_inc(s_big, mant[0], guard, sticky, round_mode_i);
    mant_r = {1'b0, mant} + {{M{1'b0}}, up};
    if (mant_r[M]) begin
      mant  = mant_r[M:1];
      exp_i = exp_i + 1;
    end else begin
      mant  = mant_r[M-1:0];
    end
    // Exact cancellation yields +0 except when rounding toward minus infinity.
    zs = (round_mode_i == RND_RDN) ? (s_big | s_sml) : (s_big & s_sml);

    z_o   = '0;
    exc_o = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sbe))) begin
      z_o           = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
      exc_o[EXC_NV] = a_inf && b_inf;
    end else if (a_inf) begin
      z_o = {sa, {E{1'b1}}, {F{1'b0}}};
    end else if (b_inf) begin
      z_o = {sbe, {E{1'b1}}, {F{1'b0}}};
    end else if (sum == '0) begin
      z_o = {zs, {(E+F){1'b0}}};
    end else if (exp_i >= EMAX) begin
      z_o = ovf_to_inf(s_big, round_mode_i) ? {s_big, {E{1'b1}}, {F{1'b0}}}
                                            : {s_big, {(E-1){1'b1}}, 1'b0, {F{1'b1}}};
      exc_o[EXC_OF] = 1'b1;
      exc_o[EXC_NX] = 1'b1;
    end else if (exp_i <= 0) begin
      z_o           = {s_big, {(E+F){1'b0}}};
      exc_o[EXC_UF] = 1'b1;
      exc_o[EXC_NX] = 1'b1;
    end else begin
      z_o           = {s_big, exp_i[E-1:0], mant[F-1:0]};
      exc_o[EXC_NX] = guard | sticky;
    end
  end

endmodule

// File: rtl/multiplier.sv
// Combinational FP multiplier; subnormal inputs and results are flushed to zero.
module multiplier
  import nn_fp_pkg::*;
#(
  parameter int exp_width  = 8,
  parameter int mant_width = 24
) (
  input  logic [exp_width+mant_width-1:0] a_i,
  input  logic [exp_width+mant_width-1:0] b_i,
  input  logic [2:0]                      round_mode_i,
  output logic [exp_width+mant_width-1:0] z_o,
  output logic [4:0]                      exc_o
);
  localparam int E    = exp_width;
  localparam int F    = mant_width - 1;
  localparam int M    = mant_width;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int EMAX = (1 << E) - 1;

  logic         sa, sb, sz;
  logic [E-1:0] ea, eb;
  logic [F-1:0] fa, fb;
  logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [2*M-1:0] prod;
  logic [M-1:0] mant;
  logic [M:0]   mant_r;
  logic         guard, sticky, up;
  int           exp_i;

  assign {sa, ea, fa} = a_i;
  assign {sb, eb, fb} = b_i;

  always_comb begin
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    sz     = sa ^ sb;
    prod   = {{M{1'b0}}, ~a_zero, fa} * {{M{1'b0}}, ~b_zero, fb};
    exp_i  = int'(ea) + int'(eb) - BIAS;
    if (prod[2*M-1]) begin
      mant   = prod[2*M-1 -: M];
      guard  = prod[M-1];
      sticky = |prod[M-2:0];
      exp_i  = exp_i + 1;
    end else begin
      mant   = prod[2*M-2 -: M];
      guard  = prod[M-2];
      sticky = |prod[M-3:0];
    end
    up     = round_inc(sz, mant[0], guard, sticky, round_mode_i);
    mant_r = {1'b0, mant} + {{M{1'b0}}, up};
    if (mant_r[M]) begin
      mant  = mant_r[M:1];
      exp_i = exp_i + 1;
    end else begin
      mant  = mant_r[M-1:0];
    end

    z_o   = '0;
    exc_o = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      z_o           = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
      exc_o[EXC_NV] = (a_inf && b_zero) || (b_inf && a_zero);
    end else if (a_inf || b_inf) begin
      z_o = {sz, {E{1'b1}}, {F{1'b0}}};
    end else if (a_zero || b_zero) begin
      z_o = {sz, {(E+F){1'b0}}};
    end else if (exp_i >= EMAX) begin
      z_o = ovf_to_inf(sz, round_mode_i) ? {sz, {E{1'b1}}, {F{1'b0}}}
                                         : {sz, {(E-1){1'b1}}, 1'b0, {F{1'b1}}};
      exc_o[EXC_OF] = 1'b1;
      exc_o[EXC_NX] = 1'b1;
    end else if (exp_i <= 0) begin
      z_o           = {sz, {(E+F){1'b0}}};
      exc_o[EXC_UF] = 1'b1;
      exc_o[EXC_NX] = 1'b1;
    end else begin
      z_o           = {sz, exp_i[E-1:0], mant[F-1:0]};
      exc_o[EXC_NX] = guard | sticky;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// One neuron pre-activation z = bias + sum(x*w) over n_inputs streamed pairs,
// with a registered product stage and a valid/ready result handoff.
module neuron_mac
  import nn_fp_pkg::*;
#(
  parameter int exp_width  = 8,
  parameter int mant_width = 24,
  parameter int n_inputs   = 4
) (
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic [2:0]                      round_mode,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [exp_width+mant_width-1:0] in_x,
  input  logic [exp_width+mant_width-1:0] in_w,
  input  logic [exp_width+mant_width-1:0] in_bias,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [exp_width+mant_width-1:0] out_sum,
  output logic [4:0]                      out_exceptions
);
  localparam int W     = exp_width + mant_width;
  localparam int CNT_W = $clog2(n_inputs + 1);

  state_e           state_q;
  logic             in_ready_q, out_valid_q, prod_vld_q;
  logic [W-1:0]     acc_q, acc_d, prod_q;
  logic [4:0]       exc_q, exc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     mul_z, add_z;
  logic [4:0]       mul_exc, add_exc;
  logic             accept, last_pair;

  multiplier #(.exp_width(exp_width), .mant_width(mant_width)) u_mul (
    .a_i(in_x), .b_i(in_w), .round_mode_i(round_mode), .z_o(mul_z), .exc_o(mul_exc)
  );

  add_sub #(.exp_width(exp_width), .mant_width(mant_width)) u_add (
    .a_i(acc_q), .b_i(prod_q), .op_i(1'b0), .round_mode_i(round_mode),
    .z_o(add_z), .exc_o(add_exc)
  );

  assign accept    = in_valid & in_ready_q;
  assign last_pair = (cnt_q == CNT_W'(n_inputs - 1));

  // The first pair of a neuron restarts the accumulator from the bias.
  always_comb begin
    acc_d = acc_q;
    exc_d = exc_q;
    if (prod_vld_q) begin
      acc_d = add_z;
      exc_d = exc_d | add_exc;
    end
    if (accept) exc_d = exc_d | mul_exc;
    if (accept && state_q == IDLE) begin
      acc_d = in_bias;
      exc_d = mul_exc;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      prod_q      <= '0;
      exc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      acc_q      <= acc_d;
      exc_q      <= exc_d;
      prod_vld_q <= accept;
      if (accept) prod_q <= mul_z;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          cnt_q      <= '0;
          if (accept) begin
            cnt_q <= CNT_W'(1);
            if (n_inputs == 1) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_pair) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_sum        = acc_q;
  assign out_exceptions = exc_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: a 4-input instance plus a 1-input instance
// sharing clock and reset, checked against hand-computed IEEE-754 results.
module tb_neuron_mac;
  import nn_fp_pkg::*;

  localparam logic [31:0] TWO     = 32'h4000_0000;
  localparam logic [31:0] THREE   = 32'h4040_0000;
  localparam logic [31:0] FOUR    = 32'h4080_0000;
  localparam logic [31:0] NEG1    = 32'hbf80_0000;
  localparam logic [31:0] QUARTER = 32'h3e80_0000;
  localparam logic [31:0] FMAX    = 32'h7f7f_ffff;
  localparam logic [31:0] JUNK    = 32'h4120_0000;

  logic        clk, rst_l;
  logic [2:0]  round_mode;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_x, in_w, in_bias, out_sum;
  logic [4:0]  out_exceptions;
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [31:0] in_x1, in_w1, in_bias1, out_sum1;
  logic [4:0]  out_exceptions1;

  logic [31:0] xs[4];
  logic [31:0] ws[4];
  logic [31:0] held_sum;
  logic [4:0]  held_exc;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          lat;

  neuron_mac #(.exp_width(8), .mant_width(24), .n_inputs(4)) dut (
    .clk(clk), .rst_l(rst_l), .round_mode(round_mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_bias(in_bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_exceptions(out_exceptions)
  );

  neuron_mac #(.exp_width(8), .mant_width(24), .n_inputs(1)) dut1 (
    .clk(clk), .rst_l(rst_l), .round_mode(round_mode),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_x(in_x1), .in_w(in_w1), .in_bias(in_bias1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_exceptions(out_exceptions1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds xs/ws (optional bubble before pair 3) and returns edges from the
  // first accept to the edge where out_valid is seen high.
  task automatic run4(input logic [31:0] b, input int gap, output int latency);
    latency = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          step();
          latency++;
        end
      end
      in_valid = 1'b1;
      in_x     = xs[i];
      in_w     = ws[i];
      in_bias  = (i == 0) ? b : JUNK;
      step();
      latency++;
    end
    in_valid = 1'b0;
    in_x     = '0;
    in_w     = '0;
    while (!out_valid && latency < 20) begin
      step();
      latency++;
    end
  endtask

  initial begin
    rst_l = 1'b0; round_mode = RND_RNE;
    in_valid = 1'b0; in_x = '0; in_w = '0; in_bias = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_x1 = '0; in_w1 = '0; in_bias1 = '0; out_ready1 = 1'b1;
    repeat (2) step();
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_sum", out_sum, 32'd0);
    check("rst out_exc", 32'(out_exceptions), 32'd0);
    check("rst in_ready1", 32'(in_ready1), 32'd0);
    rst_l = 1'b1;
    #2;
    check("release in_ready before edge", 32'(in_ready), 32'd0);
    step();
    check("release in_ready after edge", 32'(in_ready), 32'd1);

    // 0.5 + 1*1 + 2*0.5 + (-1)*3 + 0.25*4 = 0.5
    xs = '{FP_ONE, TWO, NEG1, QUARTER};
    ws = '{FP_ONE, FP_HALF, THREE, FOUR};
    run4(FP_HALF, 0, lat);
    check("n1 latency", 32'(lat), 32'd5);
    check("n1 out_valid", 32'(out_valid), 32'd1);
    check("n1 out_sum", out_sum, 32'h3f00_0000);
    check("n1 out_exc", 32'(out_exceptions), 32'd0);
    check("n1 in_ready in DONE", 32'(in_ready), 32'd0);
    step();
    check("n1 out_valid after hs", 32'(out_valid), 32'd0);
    check("n1 in_ready after hs", 32'(in_ready), 32'd1);

    // Bias 0, four 1*1 pairs with two bubbles: sum 4.0, latency +2.
    xs = '{FP_ONE, FP_ONE, FP_ONE, FP_ONE};
    ws = '{FP_ONE, FP_ONE, FP_ONE, FP_ONE};
    run4(FP_ZERO, 2, lat);
    check("bubble latency", 32'(lat), 32'd7);
    check("bubble out_sum", out_sum, 32'h4080_0000);
    check("bubble out_exc", 32'(out_exceptions), 32'd0);
    step();

    // Output back-pressure for 5 cycles.
    out_ready = 1'b0;
    xs = '{FP_ONE, TWO, NEG1, QUARTER};
    ws = '{FP_ONE, FP_HALF, THREE, FOUR};
    run4(FP_HALF, 0, lat);
    check("stall latency", 32'(lat), 32'd5);
    held_sum = out_sum;
    held_exc = out_exceptions;
    check("stall sum at valid", held_sum, 32'h3f00_0000);
    for (int c = 0; c < 5; c++) begin
      step();
      check("stall out_sum stable", out_sum, held_sum);
      check("stall out_exc stable", 32'(out_exceptions), 32'(held_exc));
      check("stall in_ready low", 32'(in_ready), 32'd0);
      check("stall out_valid high", 32'(out_valid), 32'd1);
    end

    // Next neuron presented during the handshake edge: max*2 overflows to +inf.
    xs = '{FMAX, FP_ONE, FP_ONE, FP_ONE};
    ws = '{TWO, FP_ONE, FP_ONE, FP_ONE};
    in_valid = 1'b1; in_x = xs[0]; in_w = ws[0]; in_bias = FP_ZERO;
    out_ready = 1'b1;
    step();
    check("hs in_ready restored", 32'(in_ready), 32'd1);
    check("hs out_valid cleared", 32'(out_valid), 32'd0);
    run4(FP_ZERO, 0, lat);
    check("ovf latency", 32'(lat), 32'd5);
    check("ovf out_sum", out_sum, 32'h7f80_0000);
    check("ovf flag", 32'(out_exceptions[EXC_OF]), 32'd1);
    step();

    xs = '{FP_ONE, TWO, NEG1, QUARTER};
    ws = '{FP_ONE, FP_HALF, THREE, FOUR};
    run4(FP_HALF, 0, lat);
    check("post-ovf out_sum", out_sum, 32'h3f00_0000);
    check("post-ovf out_exc", 32'(out_exceptions), 32'd0);
    step();

    // Reset after 2 of 4 pairs.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_x = xs[i]; in_w = ws[i]; in_bias = FP_HALF;
      step();
    end
    rst_l = 1'b0;
    #1;
    check("midrst in_ready", 32'(in_ready), 32'd0);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst out_sum", out_sum, 32'd0);
    check("midrst out_exc", 32'(out_exceptions), 32'd0);
    in_valid = 1'b0;
    step();
    step();
    check("midrst in_ready held", 32'(in_ready), 32'd0);
    rst_l = 1'b1;
    #2;
    check("midrst release before edge", 32'(in_ready), 32'd0);
    step();
    check("midrst release after edge", 32'(in_ready), 32'd1);
    run4(FP_HALF, 0, lat);
    check("fresh latency", 32'(lat), 32'd5);
    check("fresh out_sum", out_sum, 32'h3f00_0000);
    check("fresh out_exc", 32'(out_exceptions), 32'd0);
    step();

    // Single-input neuron: 1.0 + 2*3 = 7.0
    in_valid1 = 1'b1; in_x1 = TWO; in_w1 = THREE; in_bias1 = FP_ONE;
    step();
    check("n=1 in_ready after accept", 32'(in_ready1), 32'd0);
    check("n=1 out_valid after accept", 32'(out_valid1), 32'd0);
    in_valid1 = 1'b0;
    step();
    check("n=1 out_valid", 32'(out_valid1), 32'd1);
    check("n=1 out_sum", out_sum1, 32'h40e0_0000);
    check("n=1 out_exc", 32'(out_exceptions1), 32'd0);
    step();
    check("n=1 out_valid after hs", 32'(out_valid1), 32'd0);
    check("n=1 in_ready after hs", 32'(in_ready1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Floating-point multiply-accumulate stage that computes one neuron pre-activation, z = bias + Σ x[i]·w[i], over a fixed number of streamed (input, weight) pairs. It sits directly upstream of the sigmoid activation stage: `out_sum` drives the sigmoid's `in_x`. It reuses the existing combinational `multiplier` and `add_sub` units. Results are handed off through a valid/ready handshake.

## Interface
- `exp_width`, default 8: exponent width.
- `mant_width`, default 24: mantissa width including hidden bit. The word width is W = exp_width + mant_width.
- `n_inputs`, default 4: pairs per neuron. Must be ≥ 1.
- `clk` in, 1: the single clock. All state changes on its rising edge.
- `rst_l` in, 1: asynchronous, active-low reset.
- `round_mode` in, 3: passed unchanged to all FP units.
- `in_valid` in, 1: the current `in_x`/`in_w` pair is valid.
- `in_ready` out, 1: the block accepts a pair this cycle.
- `in_x` in, W: activation operand.
- `in_w` in, W: weight operand.
- `in_bias` in, W: bias. Sampled only on the first pair of each neuron.
- `out_valid` out, 1: `out_sum` and `out_exceptions` are valid.
- `out_ready` in, 1: the consumer accepts the result.
- `out_sum` out, W: accumulated pre-activation.
- `out_exceptions` out, 5: sticky OR of all FP exception flags raised during this neuron.

## Operation
- A handshake occurs when `in_valid & in_ready` at a rising edge. The output handshake occurs when `out_valid & out_ready`.
- Datapath:
  - The multiplier forms `in_x·in_w` combinationally.
  - On each accepted pair, the product is registered into `prod_reg` and `prod_vld` is set to 1.
  - At the next edge, `acc <= acc + prod_reg` via `add_sub` with operation 0 (add), and `prod_vld` is cleared unless a new pair is accepted.
- First pair of a neuron: `acc <= in_bias` and `exc <= mul_exc` in the same edge. The product is added at the following edge.
- Exception accumulation:
  - `exc` ORs in the multiplier flags on every accepted pair.
  - `exc` ORs in the adder flags on every edge where `prod_vld` is 1.
  - Flags from units whose result is unused are ignored.
- Counter `cnt`, width $clog2(n_inputs+1): cleared in IDLE and incremented on each accepted pair.
- FSM states:
  - IDLE: `in_ready` = 1. On the first handshake, go to ACCUM, or to DRAIN when n_inputs = 1.
  - ACCUM: `in_ready` = 1. On the handshake that makes `cnt` reach n_inputs, go to DRAIN. Cycles with `in_valid` = 0 are bubbles: no count change, and any pending product is still accumulated.
  - DRAIN: `in_ready` = 0. The final product is added. Go to DONE and set `out_valid` = 1 at the same edge.
  - DONE: `in_ready` = 0. `out_sum`, `out_exceptions` and `out_valid` are held stable. On the output handshake, go to IDLE, clear `out_valid`, and set `in_ready` to 1 at the same edge.
- FP rules: arithmetic is standard add_sub/multiplier behaviour with no saturation. Inf and NaN propagate into `out_sum`.
- Reset:
  - Asserted asynchronously at any time, including mid-neuron or in DONE, the partial result is discarded.
  - Values while reset is asserted: state IDLE, `in_ready` = 0, `out_valid` = 0, `out_sum` = 0, `out_exceptions` = 0, `acc`/`prod_reg`/`cnt`/`exc` = 0.
  - `in_ready` is a register. It rises at the first `clk` edge after `rst_l` deasserts.

## Timing
- Throughput: one pair per cycle. Bubbles in `in_valid` simply extend the neuron.
- Latency: if the last pair is accepted at edge E, `out_valid` rises at edge E+1. This is the edge where the last product is added.
- Minimum neuron period with `out_ready` held at 1: n_inputs + 2 cycles.
  - n_inputs edges accept pairs.
  - One edge DRAIN→DONE.
  - One edge for the output handshake, which restores `in_ready`.
- There is no overlap between neurons: `in_ready` = 0 from the edge after the last accepted pair until the edge of the output handshake.
- `out_sum` never changes while `out_valid` = 1.

## Structure
- Shared package `nn_fp_pkg`, holding:
  - the FSM state enum {IDLE, ACCUM, DRAIN, DONE};
  - FP constants FP_ZERO (32'h00000000), FP_HALF (32'h3f000000) and FP_ONE (32'h3f800000);
  - exception-flag bit-position constants shared with the sigmoid stage.
- One `multiplier` instance and one `add_sub` instance are used, with FSM, counter and registers inline.
- No new sub-module is needed.

## Test plan
- n_inputs=4, bias=0.5 (3f000000), pairs (1.0,1.0), (2.0,0.5), (−1.0,3.0), (0.25,4.0) on consecutive cycles:
  - `out_valid` one cycle after the 4th accept;
  - `out_sum`=3f000000, `out_exceptions`=0.
- Bias 0, four pairs (1.0,1.0) with `in_valid` low for 2 cycles between pairs 2 and 3: `out_sum`=40800000, with latency extended by exactly 2 cycles.
- `out_ready` held low 5 cycles after `out_valid`:
  - `out_sum`/`out_exceptions` stable;
  - `in_ready`=0 throughout;
  - `in_ready` returns 1 at the handshake edge; the next neuron accepts on the following cycle.
- Pair (7f7fffff, 40000000): `out_sum`=7f800000 (+inf) with the overflow flag set. The next neuron, with normal operands, reports `out_exceptions`=0.
- `rst_l` pulsed low after 2 of 4 pairs:
  - all outputs at reset values;
  - `in_ready`=0 until the first edge after release;
  - a fresh neuron then yields a correct sum.
- n_inputs=1, bias 1.0, pair (2.0,3.0): `out_sum`=40e00000, `out_valid` one cycle after the accept.
